// File: rtl/uart_pkg.sv
// Shared UART definitions: baud timing, frame width and the receiver state set.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_9600 = 5000;
  localparam int unsigned DATA_BITS         = 8;
  localparam logic        IDLE_LEVEL        = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input; reset value is configurable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rx_uart.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit; mid-bit sampling
// off a down-counting bit timer, one-cycle valid pulse with parity/framing flags.
module rx_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  if (CLKS_PER_BIT < 16 || (CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT > 8192) begin : g_bad_cfg
    $error("rx_uart: CLKS_PER_BIT must be even, >= 16 and fit the 13-bit timer");
  end

  localparam logic [12:0] HALF_LOAD = 13'(CLKS_PER_BIT / 2 - 1);
  localparam logic [12:0] FULL_LOAD = 13'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (serial_in),
    .q    (rx_s)
  );

  rx_state_t   state_q, state_d;
  logic [12:0] tick_q, tick_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        tick_zero;

  assign tick_zero = (tick_q == '0);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    // Timer runs in every bit-timed state; a zero tick overrides with a reload below.
    if (state_q inside {START, DATA, PARITY, STOP} && !tick_zero) begin
      tick_d = tick_q - 13'd1;
    end

    case (state_q)
      IDLE: begin
        if (rx_s != IDLE_LEVEL) begin
          tick_d  = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (tick_zero) begin
          if (rx_s != IDLE_LEVEL) begin
            tick_d    = FULL_LOAD;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_zero) begin
          shift_d[bit_idx_q] = rx_s;
          tick_d             = FULL_LOAD;
          if (bit_idx_q == LAST_IDX) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick_zero) begin
          par_d   = rx_s;
          tick_d  = FULL_LOAD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick_zero) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          perr_d  = par_q ^ (^shift_q);
          ferr_d  = !rx_s;
          state_d = (rx_s == IDLE_LEVEL) ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s == IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rx_uart.sv
// Directed and randomized frame stimulus for rx_uart, checked against a frame-level model.
`timescale 1ns/1ps
module tb_rx_uart;

  localparam int unsigned C   = 16;
  // serial_in drop -> 2 sync clocks -> IDLE load edge, then half bit + 10 bits to the stop sample.
  localparam int unsigned LAT = 3 + C / 2 + 10 * C;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    int unsigned cyc;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_busy;

  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  pulse_t exp_q[$];
  pulse_t obs_q[$];

  always #5 clk = ~clk;

  rx_uart #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_parity_err(o_parity_err),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && o_valid) begin
      pulse_t p;
      p.d   = o_data;
      p.pe  = o_parity_err;
      p.fe  = o_frame_err;
      p.cyc = cyc;
      obs_q.push_back(p);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pulse_t model(input logic [7:0] b, input logic par, input logic stop,
                                   input int unsigned start);
    pulse_t p;
    int unsigned ones;
    ones  = $countones(b);
    p.d   = b;
    p.pe  = (par != ((ones % 2) == 1));
    p.fe  = (stop == 1'b0);
    p.cyc = start + LAT;
    return p;
  endfunction

  task automatic idle(input int unsigned n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    exp_q.push_back(model(b, par, stop, cyc));
    for (int i = 0; i < 11; i++) begin
      serial_in = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_pulses(input string tag);
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s.data%0d", tag, i), obs_q[i].d, exp_q[i].d);
      check($sformatf("%s.perr%0d", tag, i), obs_q[i].pe, exp_q[i].pe);
      check($sformatf("%s.ferr%0d", tag, i), obs_q[i].fe, exp_q[i].fe);
      check($sformatf("%s.cyc%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
    end
    if (exp_q.size() > 0) check({tag, ".held"}, o_data, exp_q[exp_q.size()-1].d);
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  b;
    logic        par;
    logic        stop;

    // Reset held with a toggling line
    for (int i = 0; i < 20; i++) begin
      serial_in = i[0];
      @(posedge clk);
      #1;
    end
    check("rst.data", o_data, 8'h00);
    check("rst.valid", o_valid, 1'b0);
    check("rst.perr", o_parity_err, 1'b0);
    check("rst.ferr", o_frame_err, 1'b0);
    check("rst.busy", o_busy, 1'b0);
    serial_in = 1'b1;
    reset = 1'b1;
    idle(30);
    check("rst.busy_after", o_busy, 1'b0);
    check_pulses("rst");

    // Clean frame
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    check("clean.busy", o_busy, 1'b0);
    check_pulses("clean");

    // Parity error
    send_frame(8'h01, 1'b0, 1'b1);
    idle(4);
    check_pulses("parity");

    // Framing error followed by a held break
    send_frame(8'h3C, 1'b0, 1'b0);
    serial_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("break.busy", o_busy, 1'b1);
    check_pulses("break");
    idle(5);
    check("break.released", o_busy, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(4);
    check_pulses("after_break");

    // Glitch rejection
    serial_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch.busy_hi", o_busy, 1'b1);
    idle(20);
    check("glitch.busy_lo", o_busy, 1'b0);
    check_pulses("glitch");

    // Back-to-back frames with minimum stop
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(4);
    check_pulses("b2b");

    // Reset during the data bits of 0x77
    bits = {1'b1, 1'b0, 8'h77, 1'b0};
    for (int i = 0; i < 4; i++) begin
      serial_in = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstmid.busy", o_busy, 1'b0);
    check("rstmid.data", o_data, 8'h00);
    serial_in = 1'b1;
    reset = 1'b1;
    idle(C);
    send_frame(8'h12, 1'b0, 1'b1);
    idle(4);
    check_pulses("rstmid");

    // Randomized frames, including bad parity and bad stop bits
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      par  = ($countones(b) % 2) == 1;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, par, stop);
      if (!stop) idle(C);
      else idle($urandom_range(0, C));
    end
    idle(4);
    check_pulses("rand");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_uart.md
# rx_uart

UART receiver and serial-to-parallel converter (SIPO), the downstream counterpart of the transmit path. It samples the serial line at 48 MHz and recovers frames of 11 bits: a start bit, 8 data bits LSB first, an even-parity bit and a stop bit. Each completed frame is presented as one byte with a 1-cycle valid pulse and parity/framing error flags, ready for a consumer FIFO or user logic.

## Interface
- `CLKS_PER_BIT`, 5000, system clocks per bit (48 MHz / 9600 bps); must be even and ≥ 16.
- `clk` input 1: system clock, 48 MHz.
- `reset` input 1: asynchronous, active-low reset.
- `serial_in` input 1: asynchronous serial line, idle high.
- `o_data` output 8: last received byte, held until the next frame completes.
- `o_valid` output 1: 1-cycle pulse when a frame completes.
- `o_parity_err` output 1: parity mismatch on the frame; valid only with `o_valid`.
- `o_frame_err` output 1: stop bit sampled 0; valid only with `o_valid`.
- `o_busy` output 1: high in every state except IDLE.

## Operation
- `serial_in` passes through a 2-FF synchronizer (reset value 1). All decisions use the synchronized signal `rx_s`.
- Bit timer: 13-bit down-counter `tick_cnt`. `bit_idx` is a 3-bit data index.
- FSM states and transitions:
  - IDLE: when `rx_s` is 0, load `tick_cnt` with CLKS_PER_BIT/2−1 and go to START.
  - START: on `tick_cnt`=0, sample `rx_s`.
    - 0: reload CLKS_PER_BIT−1, `bit_idx`=0, go to DATA.
    - 1: glitch; return to IDLE with no output.
  - DATA: on each `tick_cnt`=0, shift `rx_s` into bit `bit_idx` (LSB first) and reload. After `bit_idx`=7, go to PARITY.
  - PARITY: on `tick_cnt`=0, capture `rx_s` as `par_bit`, reload, go to STOP.
  - STOP: on `tick_cnt`=0, sample `rx_s`, then:
    - update `o_data`, `o_valid`=1;
    - `o_parity_err` = `par_bit` XOR (^data);
    - `o_frame_err` = !`rx_s`.
    - If `rx_s`=1, go to IDLE. If `rx_s`=0, go to BREAK.
  - BREAK: wait until `rx_s`=1, then go to IDLE. No output pulses in this state.
- Even parity: a frame is error-free when `par_bit` equals the XOR of the 8 data bits.
- A frame with errors is still delivered: `o_valid` pulses and the flags are set.
- Reset mid-frame: the FSM returns to IDLE immediately and the partial byte is discarded.

## Timing
- Reset values:
  - `o_data`=0x00, `o_valid`=0, `o_parity_err`=0, `o_frame_err`=0, `o_busy`=0;
  - synchronizer FFs = 1, state = IDLE.
- Synchronizer latency: 2 clocks from a `serial_in` edge to `rx_s`.
- Sample points are measured from the cycle `rx_s` first reads 0 (call it t0):
  - start bit: t0 + CLKS_PER_BIT/2;
  - data bit k (k = 0..7): t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - parity bit: t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT;
  - stop bit: t0 + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT.
- Outputs:
  - `o_valid`, `o_data` and both flags are registered and appear 1 clock after the stop sample.
  - `o_valid` is high for exactly 1 clock.
  - The flags hold their values until the next `o_valid`.
- Back-to-back frames: the FSM is in IDLE from the stop sample onward, so a start edge arriving CLKS_PER_BIT/2 later is caught without loss.
- Timing tolerance: ±4% total baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - `CLKS_PER_BIT_9600` = 5000;
  - `DATA_BITS` = 8;
  - state enum `rx_state_t` {IDLE, START, DATA, PARITY, STOP, BREAK};
  - `IDLE_LEVEL` = 1'b1.
- Sub-module `sync_2ff`: a 2-flop synchronizer with a parameterized reset value. It is reused for other asynchronous inputs.

## Test plan
All scenarios use CLKS_PER_BIT=16 for speed.
- Reset: hold `reset`=0 with `serial_in` toggling → all outputs 0, `o_busy`=0. Release reset → no `o_valid`.
- Clean frame: byte 0xA5, parity 0, stop 1 → one `o_valid`, `o_data`=0xA5, both flags 0, pulse at t0+8+160+1.
- Parity error: byte 0x01 sent with parity 0 → `o_valid`, `o_data`=0x01, `o_parity_err`=1, `o_frame_err`=0.
- Framing error / break: byte 0x3C with stop=0, then line held low 40 clocks → `o_frame_err`=1, `o_data`=0x3C, FSM stays in BREAK with no further `o_valid`. Line returns high, then frame 0x55 → 0x55 received clean.
- Glitch rejection: low pulse of 4 clocks on an idle line → `o_busy` pulses, no `o_valid`, FSM back in IDLE. Back-to-back 0x00 and 0xFF with minimum stop → two pulses, correct data, no errors.
- Reset mid-frame: assert `reset` during DATA of 0x77, release, then send 0x12 → only 0x12 reported.
